// File: rtl/gate_truth_sweep.sv
// N-input gate (NOR/NAND/OR/AND/XOR/XNOR/INV/BUF) with registered output and an exhaustive truth-table sweep engine.
// Optional self-check against an expected table is enabled by defining GATE_TT_CHECK_EN.
module gate_truth_sweep #(
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic [N-1:0]          a,
  output logic                  f,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          idx,
`ifdef GATE_TT_CHECK_EN
  input  logic [(1<<N)-1:0]     tt_exp,
  output logic [N:0]            err_cnt,
  output logic                  pass,
`endif
  output logic [(1<<N)-1:0]     tt
);

  localparam int TTW = 1 << N;

  if (N < 1 || N > 6) begin : g_bad_n
    $error("gate_truth_sweep: N must be in 1..6");
  end

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic             f_q, f_d;
  logic [N-1:0]     idx_q, idx_d;
  logic [TTW-1:0]   tt_q, tt_d;
  logic             sweep_bit;
  logic             last_code;

  function automatic logic gate_fn(input logic [2:0] m, input logic [N-1:0] v);
    case (m)
      3'd0:    return ~(|v);
      3'd1:    return ~(&v);
      3'd2:    return |v;
      3'd3:    return &v;
      3'd4:    return ^v;
      3'd5:    return ~(^v);
      3'd6:    return ~v[0];
      default: return v[0];
    endcase
  endfunction

  assign sweep_bit = gate_fn(mode_q, idx_q);
  assign last_code = (idx_q == {N{1'b1}});

`ifdef GATE_TT_CHECK_EN
  logic [TTW-1:0] tt_exp_q, tt_exp_d;
  logic [N:0]     err_cnt_q, err_cnt_d;
  logic           pass_q, pass_d;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    f_d     = f_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
`ifdef GATE_TT_CHECK_EN
    tt_exp_d  = tt_exp_q;
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        f_d = gate_fn(mode, a);
        if (start) begin
          mode_d  = mode;
          tt_d    = '0;
          idx_d   = '0;
          state_d = S_SWEEP;
`ifdef GATE_TT_CHECK_EN
          tt_exp_d  = tt_exp;
          err_cnt_d = '0;
`endif
        end
      end
      S_SWEEP: begin
        tt_d[idx_q] = sweep_bit;
        f_d         = sweep_bit;
`ifdef GATE_TT_CHECK_EN
        err_cnt_d = err_cnt_q + {{N{1'b0}}, (sweep_bit != tt_exp_q[idx_q])};
`endif
        // Terminal code parks idx at 0 rather than wrapping
        if (last_code) begin
          idx_d   = '0;
          state_d = S_DONE;
`ifdef GATE_TT_CHECK_EN
          pass_d = (err_cnt_d == '0);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      f_q     <= 1'b0;
      idx_q   <= '0;
      tt_q    <= '0;
`ifdef GATE_TT_CHECK_EN
      tt_exp_q  <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      f_q     <= f_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
`ifdef GATE_TT_CHECK_EN
      tt_exp_q  <= tt_exp_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
`endif
    end
  end

  assign f    = f_q;
  assign busy = (state_q == S_SWEEP);
  assign done = (state_q == S_DONE);
  assign idx  = idx_q;
  assign tt   = tt_q;
`ifdef GATE_TT_CHECK_EN
  assign err_cnt = err_cnt_q;
  assign pass    = pass_q;
`endif

endmodule
